mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, SHALL set the wait states between request capture and response (legal 0..15).
REQ-002 Parameter DEPTH, default 256, SHALL set the number of 8-bit words (address width fixed at 8).
REQ-003 clock  input  1  SHALL be the sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be synchronous, active-low: reset==0 at a rising edge resets the block.
REQ-005 MemRead  input  1  SHALL be the data-port read request.
REQ-006 MemWrite  input  1  SHALL be the data-port write request.
REQ-007 address  input  8  SHALL be the data-port word address.
REQ-008 data  input  8  SHALL be the write data.
REQ-009 q  output  8  SHALL be the read data, held until the next completed read.
REQ-010 ready  output  1  SHALL be a one-cycle completion strobe.
REQ-011 busy  output  1  SHALL be high while a request is in flight (states WAIT and RESP).
REQ-012 err  output  1  SHALL flag a protocol-error response; valid only while ready==1.
REQ-013 address_pc  input  8  SHALL be the instruction-fetch address.
REQ-014 q_pc  output  8  SHALL be the registered instruction-fetch data.
REQ-015 rd_count, wr_count  output  16 each  SHALL count completed reads and writes.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, WAIT, RESP.
REQ-017 In IDLE, if MemRead|MemWrite==1 at an edge, the block SHALL latch address, data and the request type, then go to WAIT with counter=WAIT_CYCLES, or to RESP if WAIT_CYCLES==0.
REQ-018 In WAIT, the counter SHALL decrement each edge; at the edge where counter==1, the state SHALL become RESP and the access SHALL execute.
REQ-019 ready SHALL be 1 only in RESP, exactly WAIT_CYCLES+1 cycles after the capture edge; RESP SHALL always return to IDLE on the next edge.
REQ-020 Request inputs SHALL be ignored in WAIT and RESP; a request still high in the cycle after RESP SHALL be captured as a new request.
REQ-021 Latched values only SHALL be used; changes to address or data after capture SHALL have no effect.
REQ-022 Read: q SHALL take mem[latched address] on entry to RESP; rd_count SHALL increment.
REQ-023 Write: mem[latched address] SHALL take latched data on entry to RESP; q SHALL be unchanged; wr_count SHALL increment.
REQ-024 MemRead and MemWrite both 1 at capture SHALL be a protocol error: normal timing, no memory access, q unchanged, no count change, err=1 with ready.
REQ-025 rd_count and wr_count SHALL saturate at 16'hFFFF.
REQ-026 Addresses >= DEPTH SHALL wrap modulo DEPTH.
REQ-027 q_pc SHALL equal mem[address_pc] as sampled at the previous edge, every cycle, independent of FSM state.
REQ-028 A write and a fetch to the same address at the same edge SHALL return the old data on q_pc.

Reset
REQ-029 On reset, the following SHALL apply: state=IDLE, counter=0, q=0, q_pc=0, ready=0, busy=0, err=0, rd_count=0, wr_count=0.
REQ-030 Reset SHALL NOT alter memory contents.
REQ-031 Reset asserted in WAIT or RESP SHALL abort the request: no write occurs, no ready is issued, and no count changes.

Verification
REQ-032 WAIT_CYCLES=2, reset released; MemWrite=1, address=8'h10, data=8'hA5 for 1 cycle -> busy=1, ready=1 exactly 3 cycles after capture, err=0, wr_count=1, q=0.
REQ-033 Then MemRead=1, address=8'h10 -> ready=1 after 3 cycles, q=8'hA5 held afterward, rd_count=1; address_pc=8'h10 -> q_pc=8'hA5 the next cycle.
REQ-034 MemRead=MemWrite=1, address=8'h10, data=8'h00 -> ready=1, err=1, mem[8'h10] still 8'hA5, counts unchanged.
REQ-035 Write 8'h3C to 8'h20, reset=0 pulsed during WAIT -> no ready; read of 8'h20 returns prior contents; all outputs at reset values.
REQ-036 WAIT_CYCLES=0, MemRead held high for 4 cycles -> ready pulses on alternate cycles, busy toggles, rd_count=2.
REQ-037 Force rd_count to 16'hFFFF and complete one read -> rd_count stays 16'hFFFF.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: wait-stated single-port memory responder with a registered instruction-fetch port
module mem_responder #(
    parameter int WAIT_CYCLES = 2,
    parameter int DEPTH       = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [7:0]  address,
    input  logic [7:0]  data,
    input  logic [7:0]  address_pc,
    output logic [7:0]  q,
    output logic [7:0]  q_pc,
    output logic        ready,
    output logic        busy,
    output logic        err,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic [7:0]  r_addr;
    logic [7:0]  r_data;
    logic        r_rd;
    logic        r_wr;
    logic        r_err;
    logic [7:0]  r_q;
    logic [7:0]  r_q_pc;
    logic [15:0] r_rd_count;
    logic [15:0] r_wr_count;
    logic [7:0]  r_mem [DEPTH];

    logic          w_cap;
    logic          w_exec;
    logic          w_rd;
    logic          w_wr;
    logic [7:0]    w_addr;
    logic [7:0]    w_data;
    logic          w_do_rd;
    logic          w_do_wr;
    logic [AW-1:0] w_idx;
    logic [AW-1:0] w_pc_idx;

    // With zero wait states the access executes on the capture edge itself, so
    // the live inputs stand in for the latched copy during that one edge.
    assign w_cap    = (r_state == S_IDLE) && (MemRead || MemWrite);
    assign w_exec   = (w_cap && WAIT_CYCLES == 0) || (r_state == S_WAIT && r_cnt == 4'd1);
    assign w_rd     = w_cap ? MemRead  : r_rd;
    assign w_wr     = w_cap ? MemWrite : r_wr;
    assign w_addr   = w_cap ? address  : r_addr;
    assign w_data   = w_cap ? data     : r_data;
    assign w_do_rd  = w_exec && w_rd && !w_wr;
    assign w_do_wr  = w_exec && w_wr && !w_rd;
    assign w_idx    = AW'(32'(w_addr) % DEPTH);
    assign w_pc_idx = AW'(32'(address_pc) % DEPTH);

    assign ready    = (r_state == S_RESP);
    assign busy     = (r_state != S_IDLE);
    assign err      = ready && r_err;
    assign q        = r_q;
    assign q_pc     = r_q_pc;
    assign rd_count = r_rd_count;
    assign wr_count = r_wr_count;

    // Request FSM, read data, fetch port and completion counters.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_addr     <= 8'd0;
            r_data     <= 8'd0;
            r_rd       <= 1'b0;
            r_wr       <= 1'b0;
            r_err      <= 1'b0;
            r_q        <= 8'd0;
            r_q_pc     <= 8'd0;
            r_rd_count <= 16'd0;
            r_wr_count <= 16'd0;
        end else begin
            r_state <= w_exec ? S_RESP : (w_cap || (r_state == S_WAIT)) ? S_WAIT : S_IDLE;
            r_cnt   <= w_cap ? 4'(WAIT_CYCLES) : (r_state == S_WAIT) ? r_cnt - 4'd1 : r_cnt;
            if (w_cap) begin
                r_addr <= address;
                r_data <= data;
                r_rd   <= MemRead;
                r_wr   <= MemWrite;
            end
            if (w_exec)
                r_err <= w_rd && w_wr;
            if (w_do_rd)
                r_q <= r_mem[w_idx];
            r_q_pc     <= r_mem[w_pc_idx];
            r_rd_count <= (w_do_rd && r_rd_count != 16'hFFFF) ? r_rd_count + 16'd1 : r_rd_count;
            r_wr_count <= (w_do_wr && r_wr_count != 16'hFFFF) ? r_wr_count + 16'd1 : r_wr_count;
        end
    end

    // Memory array is never cleared; a reset edge suppresses any pending write.
    always_ff @(posedge clock) begin
        if (reset && w_do_wr)
            r_mem[w_idx] <= w_data;
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench for mem_responder (W=2/D=256 and W=0/D=16 instances)
module tb_mem_responder;
    typedef struct {
        int          cyc;
        logic [7:0]  q;
        logic        err;
        logic [15:0] rd;
        logic [15:0] wr;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t qa[$];
    exp_t qb[$];

    logic        a_rd = 0, a_wr = 0, b_rd = 0, b_wr = 0;
    logic [7:0]  a_addr = 0, a_data = 0, a_pc = 0, b_addr = 0, b_data = 0, b_pc = 0;
    logic [7:0]  a_q, a_q_pc, b_q, b_q_pc;
    logic        a_ready, a_busy, a_err, b_ready, b_busy, b_err;
    logic [15:0] a_rdc, a_wrc, b_rdc, b_wrc;

    mem_responder #(.WAIT_CYCLES(2), .DEPTH(256)) dut_a (
        .clock(clock), .reset(reset), .MemRead(a_rd), .MemWrite(a_wr),
        .address(a_addr), .data(a_data), .address_pc(a_pc),
        .q(a_q), .q_pc(a_q_pc), .ready(a_ready), .busy(a_busy), .err(a_err),
        .rd_count(a_rdc), .wr_count(a_wrc)
    );

    mem_responder #(.WAIT_CYCLES(0), .DEPTH(16)) dut_b (
        .clock(clock), .reset(reset), .MemRead(b_rd), .MemWrite(b_wr),
        .address(b_addr), .data(b_data), .address_pc(b_pc),
        .q(b_q), .q_pc(b_q_pc), .ready(b_ready), .busy(b_busy), .err(b_err),
        .rd_count(b_rdc), .wr_count(b_wrc)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor for instance A: every ready pops and checks one expected response.
    always @(negedge clock) begin
        exp_t e;
        if (a_ready !== 1'b0) begin
            if (qa.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL a_unexpected_ready: got ready %b expected 0 (cycle %0d)", a_ready, cyc);
            end else begin
                e = qa.pop_front();
                chk("a_ready_cycle", cyc, e.cyc);
                chk("a_q", {24'd0, a_q}, {24'd0, e.q});
                chk("a_err", {31'd0, a_err}, {31'd0, e.err});
                chk("a_rd_count", {16'd0, a_rdc}, {16'd0, e.rd});
                chk("a_wr_count", {16'd0, a_wrc}, {16'd0, e.wr});
            end
        end
    end

    // Monitor for instance B.
    always @(negedge clock) begin
        exp_t e;
        if (b_ready !== 1'b0) begin
            if (qb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL b_unexpected_ready: got ready %b expected 0 (cycle %0d)", b_ready, cyc);
            end else begin
                e = qb.pop_front();
                chk("b_ready_cycle", cyc, e.cyc);
                chk("b_q", {24'd0, b_q}, {24'd0, e.q});
                chk("b_err", {31'd0, b_err}, {31'd0, e.err});
                chk("b_rd_count", {16'd0, b_rdc}, {16'd0, e.rd});
                chk("b_wr_count", {16'd0, b_wrc}, {16'd0, e.wr});
            end
        end
    end

    // Drive one request for a single cycle, then scramble the inputs so that
    // only the latched copy can produce the expected result.
    task automatic issue(input bit b, input logic rd, input logic wr, input logic [7:0] ad,
                         input logic [7:0] dt, input logic [7:0] eq, input logic ee,
                         input logic [15:0] erd, input logic [15:0] ewr, input bit push);
        exp_t e;
        @(negedge clock);
        e.cyc = cyc + (b ? 1 : 3);
        e.q   = eq;
        e.err = ee;
        e.rd  = erd;
        e.wr  = ewr;
        if (b) begin
            b_rd = rd; b_wr = wr; b_addr = ad; b_data = dt;
        end else begin
            a_rd = rd; a_wr = wr; a_addr = ad; a_data = dt;
        end
        if (push && b) qb.push_back(e);
        if (push && !b) qa.push_back(e);
        @(negedge clock);
        chk(b ? "b_busy" : "a_busy", {31'd0, b ? b_busy : a_busy}, 32'd1);
        if (b) begin
            b_rd = 0; b_wr = 0; b_addr = ~ad; b_data = ~dt;
        end else begin
            a_rd = 0; a_wr = 0; a_addr = ~ad; a_data = ~dt;
        end
    endtask

    task automatic wait_idle(input bit b);
        int i;
        for (i = 0; i < 20 && (b ? b_busy : a_busy) !== 1'b0; i++) @(negedge clock);
        if (i == 20) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_idle_timeout: got busy 1 expected 0", b ? "b" : "a");
        end
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clock);
        chk("rst_q", {24'd0, a_q}, 32'd0);
        chk("rst_q_pc", {24'd0, a_q_pc}, 32'd0);
        chk("rst_ready", {31'd0, a_ready}, 32'd0);
        chk("rst_busy", {31'd0, a_busy}, 32'd0);
        chk("rst_err", {31'd0, a_err}, 32'd0);
        chk("rst_rd_count", {16'd0, a_rdc}, 32'd0);
        chk("rst_wr_count", {16'd0, a_wrc}, 32'd0);
        reset = 1'b1;
        issue(0, 0, 1, 8'h10, 8'hA5, 8'h00, 0, 16'd0, 16'd1, 1); wait_idle(0);
        issue(0, 1, 0, 8'h10, 8'h00, 8'hA5, 0, 16'd1, 16'd1, 1); wait_idle(0);
        repeat (2) @(negedge clock);
        chk("a_q_held", {24'd0, a_q}, 32'hA5);
        a_pc = 8'h10;
        @(negedge clock);
        chk("a_q_pc_10", {24'd0, a_q_pc}, 32'hA5);
        issue(0, 1, 1, 8'h10, 8'h00, 8'hA5, 1, 16'd1, 16'd1, 1); wait_idle(0);
        issue(0, 1, 0, 8'h10, 8'hFF, 8'hA5, 0, 16'd2, 16'd1, 1); wait_idle(0);
        issue(0, 0, 1, 8'h20, 8'h77, 8'hA5, 0, 16'd2, 16'd2, 1); wait_idle(0);
        issue(0, 0, 1, 8'h20, 8'h3C, 8'h00, 0, 16'd0, 16'd0, 0);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        chk("abort_q", {24'd0, a_q}, 32'd0);
        chk("abort_q_pc", {24'd0, a_q_pc}, 32'd0);
        chk("abort_busy", {31'd0, a_busy}, 32'd0);
        chk("abort_ready", {31'd0, a_ready}, 32'd0);
        chk("abort_err", {31'd0, a_err}, 32'd0);
        chk("abort_rd_count", {16'd0, a_rdc}, 32'd0);
        chk("abort_wr_count", {16'd0, a_wrc}, 32'd0);
        repeat (5) @(negedge clock);
        issue(0, 1, 0, 8'h20, 8'h00, 8'h77, 0, 16'd1, 16'd0, 1); wait_idle(0);
        a_pc = 8'h20;
        @(negedge clock);
        chk("a_q_pc_20", {24'd0, a_q_pc}, 32'h77);
        issue(0, 0, 1, 8'h30, 8'h11, 8'h77, 0, 16'd1, 16'd1, 1); wait_idle(0);
        a_pc = 8'h30;
        @(negedge clock);
        chk("a_q_pc_30_before", {24'd0, a_q_pc}, 32'h11);
        issue(0, 0, 1, 8'h30, 8'h22, 8'h77, 0, 16'd1, 16'd2, 1);
        repeat (2) @(negedge clock);
        chk("a_q_pc_same_edge_old", {24'd0, a_q_pc}, 32'h11);
        @(negedge clock);
        chk("a_q_pc_after_write", {24'd0, a_q_pc}, 32'h22);
        wait_idle(0);
        force dut_a.r_rd_count = 16'hFFFF;
        @(negedge clock);
        release dut_a.r_rd_count;
        issue(0, 1, 0, 8'h30, 8'h00, 8'h22, 0, 16'hFFFF, 16'd2, 1); wait_idle(0);
        chk("a_rd_count_sat", {16'd0, a_rdc}, 32'h0000FFFF);

        issue(1, 0, 1, 8'h05, 8'h66, 8'h00, 0, 16'd0, 16'd1, 1); wait_idle(1);
        begin
            exp_t e;
            @(negedge clock);
            b_rd = 1; b_addr = 8'h05;
            e.q = 8'h66; e.err = 0; e.wr = 16'd1;
            e.cyc = cyc + 1; e.rd = 16'd1; qb.push_back(e);
            e.cyc = cyc + 3; e.rd = 16'd2; qb.push_back(e);
            for (int i = 1; i <= 4; i++) begin
                @(negedge clock);
                chk("b_busy_toggle", {31'd0, b_busy}, {31'd0, i[0]});
            end
            b_rd = 0;
        end
        chk("b_rd_count_2", {16'd0, b_rdc}, 32'd2);
        issue(1, 0, 1, 8'h13, 8'h5A, 8'h66, 0, 16'd2, 16'd2, 1); wait_idle(1);
        issue(1, 1, 0, 8'h03, 8'h00, 8'h5A, 0, 16'd3, 16'd2, 1); wait_idle(1);
        b_pc = 8'h23;
        @(negedge clock);
        chk("b_q_pc_wrap", {24'd0, b_q_pc}, 32'h5A);
        repeat (3) @(negedge clock);
        chk("a_queue_drained", qa.size(), 32'd0);
        chk("b_queue_drained", qb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
